// File: rtl/eb1_lsu_trigger_resp.sv
// ---------------------------------------------------------------------------
// eb1_lsu_trigger_resp
// R-stage response for LSU data-address / store-data trigger matches.
// Registers the M-stage match vector into R, applies pair chaining (0/1, 2/3),
// resolves fired triggers into a debug-halt or breakpoint-exception request,
// and keeps sticky per-trigger hit bits plus a saturating firing-cycle count.
// ---------------------------------------------------------------------------
module eb1_lsu_trigger_resp #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_l,
    input  logic [3:0]       lsu_trigger_match_m,
    input  logic             lsu_pkt_valid_m,
    input  logic             lsu_pkt_dma_m,
    input  logic             lsu_r_hold,
    input  logic             dec_tlu_flush_lower_r,
    input  logic             dec_tlu_dbg_halted,
    input  logic [3:0]       trigger_chain,
    input  logic [3:0]       trigger_action,
    input  logic [3:0]       trigger_hit_clr,
    input  logic             trigger_cnt_clr,
    output logic [3:0]       lsu_trigger_match_r,
    output logic             lsu_trigger_halt_r,
    output logic             lsu_trigger_excp_r,
    output logic [3:0]       lsu_trigger_hit_sts,
    output logic [CNT_W-1:0] lsu_trigger_hit_cnt
);

    logic [3:0]       match_r_raw;
    logic [3:0]       chained;
    logic [3:0]       fired;
    logic             any_fired;
    logic             halt_req;
    logic [CNT_W-1:0] hit_cnt;
    logic [3:0]       hit_sts;

    // Odd chain bits have no meaning for this pairing scheme.
    logic chain_unused;
    assign chain_unused = trigger_chain[1] ^ trigger_chain[3];

    // M->R match register: flush kills the op even when R is stalled.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of block ordering.
        if (!rst_l) begin
            match_r_raw <= '0;
        end else if (dec_tlu_flush_lower_r) begin
            match_r_raw <= '0;
        end else if (!lsu_r_hold) begin
            match_r_raw <= lsu_trigger_match_m & {4{lsu_pkt_valid_m & ~lsu_pkt_dma_m}};
        end
    end

    // Pair chaining: a chained pair fires only when both members match.
    always_comb begin
        // NOTE: default assignment first so no path leaves chained unassigned
        // (which would infer a latch).
        chained = match_r_raw;
        if (trigger_chain[0]) begin
            chained[0] = match_r_raw[0] & match_r_raw[1];
            chained[1] = match_r_raw[0] & match_r_raw[1];
        end
        if (trigger_chain[2]) begin
            chained[2] = match_r_raw[2] & match_r_raw[3];
            chained[3] = match_r_raw[2] & match_r_raw[3];
        end
    end

    // Triggers are suppressed entirely while the core sits in debug mode.
    assign fired     = dec_tlu_dbg_halted ? 4'b0000 : chained;
    assign any_fired = |fired;

    // Halt has priority; the exception is only raised when no halt is.
    assign halt_req            = |(fired & trigger_action);
    assign lsu_trigger_match_r = fired;
    assign lsu_trigger_halt_r  = halt_req;
    assign lsu_trigger_excp_r  = (|(fired & ~trigger_action)) & ~halt_req;

    // Sticky hit bits: a fire in the same cycle beats the TLU clear.
    always_ff @(posedge clk) begin
        if (!rst_l) begin
            hit_sts <= '0;
        end else begin
            hit_sts <= fired | (hit_sts & ~trigger_hit_clr);
        end
    end

    // Saturating count of firing cycles; a clear coincident with a fire restarts at 1.
    always_ff @(posedge clk) begin
        if (!rst_l) begin
            hit_cnt <= '0;
        end else if (trigger_cnt_clr) begin
            hit_cnt <= any_fired ? {{(CNT_W-1){1'b0}}, 1'b1} : '0;
        end else if (any_fired && (hit_cnt != {CNT_W{1'b1}})) begin
            hit_cnt <= hit_cnt + 1'b1;
        end
    end

    assign lsu_trigger_hit_sts = hit_sts;
    assign lsu_trigger_hit_cnt = hit_cnt;

endmodule
